acc_port_arbiter: RTL and testbench

ACC_PORT_ARBITER -- requirements
Module: acc_port_arbiter

---
 rtl/acc_pkg.sv | 30 +++
 rtl/acc_port_arbiter_if.sv | 41 ++++
 rtl/rr_arb_tree.sv | 28 ++
 rtl/acc_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_acc_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared accelerator request/response types and port-index helpers
package acc_pkg;

    localparam int unsigned AccTransIdWidth = 8;

    typedef struct packed {
        logic [31:0]                insn;
        logic [31:0]                rs1;
        logic [31:0]                rs2;
        logic [2:0]                 frm;
        logic [AccTransIdWidth-1:0] trans_id;
    } accelerator_req_t;

    typedef struct packed {
        logic [31:0]                result;
        logic                       error;
        logic [AccTransIdWidth-1:0] trans_id;
    } accelerator_resp_t;

    typedef enum logic {
        LOCK_IDLE,
        LOCK_HELD
    } lock_state_e;

    // A single port still needs one index bit so the packed trans_id layout stays uniform.
    function automatic int unsigned port_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_port_arbiter_if.sv
// rtl/acc_port_arbiter_if.sv - upstream/downstream handshake bundle of the accelerator port arbiter
interface acc_port_arbiter_if
    import acc_pkg::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned MaxOutstanding = 4
);
    localparam int unsigned CntBits = $clog2(MaxOutstanding + 1);

    logic [NrPorts-1:0]              up_req_valid_i;
    logic [NrPorts-1:0]              up_req_ready_o;
    accelerator_req_t                up_req_i [NrPorts];
    logic [NrPorts-1:0]              up_resp_valid_o;
    logic [NrPorts-1:0]              up_resp_ready_i;
    accelerator_resp_t               up_resp_o;
    logic                            dn_req_valid_o;
    logic                            dn_req_ready_i;
    accelerator_req_t                dn_req_o;
    logic                            dn_resp_valid_i;
    logic                            dn_resp_ready_o;
    accelerator_resp_t               dn_resp_i;
    logic [NrPorts-1:0][CntBits-1:0] outstanding_o;
    logic                            idle_o;

    modport slave (
        input  up_req_valid_i, up_req_i, up_resp_ready_i,
        input  dn_req_ready_i, dn_resp_valid_i, dn_resp_i,
        output up_req_ready_o, up_resp_valid_o, up_resp_o,
        output dn_req_valid_o, dn_req_o, dn_resp_ready_o,
        output outstanding_o, idle_o
    );

    modport master (
        output up_req_valid_i, up_req_i, up_resp_ready_i,
        output dn_req_ready_i, dn_resp_valid_i, dn_resp_i,
        input  up_req_ready_o, up_resp_valid_o, up_resp_o,
        input  dn_req_valid_o, dn_req_o, dn_resp_ready_o,
        input  outstanding_o, idle_o
    );

endinterface

// File: rtl/rr_arb_tree.sv
// rtl/rr_arb_tree.sv - combinational round-robin picker: first requester at or after rr_ptr_i wins
module rr_arb_tree #(
    parameter int NumIn    = 2,
    parameter int IdxWidth = 1
) (
    input  logic [NumIn-1:0]    req_i,
    input  logic [IdxWidth-1:0] rr_ptr_i,
    output logic                gnt_valid_o,
    output logic [IdxWidth-1:0] gnt_idx_o
);

    int idx;

    // Scan from farthest to nearest so the last hit is the one closest to rr_ptr_i.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = 0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_i) + i) % NumIn;
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IdxWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/acc_port_arbiter.sv
// rtl/acc_port_arbiter.sv - shares one accelerator among NrPorts dispatchers with
// round-robin grant, grant lock under backpressure and per-port in-flight caps.
module acc_port_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TransIdBits    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    acc_port_arbiter_if.slave  bus
);

    localparam int unsigned PortBits = port_idx_width(NrPorts);
    localparam int unsigned CntBits  = $clog2(MaxOutstanding + 1);

    typedef logic [PortBits-1:0] port_idx_t;
    typedef logic [CntBits-1:0]  cnt_t;

    lock_state_e        state_q, state_d;
    port_idx_t          rr_ptr_q, rr_ptr_d;
    port_idx_t          lock_idx_q, lock_idx_d;
    cnt_t               cnt_q [NrPorts];
    cnt_t               cnt_d [NrPorts];

    logic [NrPorts-1:0] eligible;
    logic               arb_valid;
    port_idx_t          arb_idx;
    port_idx_t          winner;
    logic               dn_valid;
    logic               req_hs;
    port_idx_t          resp_port;
    logic               resp_port_ok;
    logic               resp_hs;
    logic               resp_legal;
    accelerator_req_t   dn_req;
    accelerator_resp_t  up_resp;

    always_comb begin
        eligible = '0;
        for (int p = 0; p < int'(NrPorts); p++) begin
            eligible[p] = bus.up_req_valid_i[p] && (cnt_q[p] < cnt_t'(MaxOutstanding));
        end
    end

    rr_arb_tree #(
        .NumIn    (int'(NrPorts)),
        .IdxWidth (int'(PortBits))
    ) i_rr_arb_tree (
        .req_i       (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    // A locked grant overrides the arbiter until the accelerator takes the request.
    always_comb begin
        winner   = (state_q == LOCK_HELD) ? lock_idx_q : arb_idx;
        dn_valid = !rst_i && ((state_q == LOCK_HELD) || arb_valid);
        req_hs   = dn_valid && bus.dn_req_ready_i;

        dn_req          = bus.up_req_i[winner];
        dn_req.trans_id = '0;
        dn_req.trans_id[TransIdBits-1:0]        = bus.up_req_i[winner].trans_id[TransIdBits-1:0];
        dn_req.trans_id[TransIdBits +: PortBits] = winner;
    end

    always_comb begin
        bus.up_req_ready_o = '0;
        if (dn_valid) begin
            bus.up_req_ready_o[winner] = bus.dn_req_ready_i;
        end
        bus.dn_req_valid_o = dn_valid;
        bus.dn_req_o       = dn_req;
    end

    // Responses carry their home port in the trans_id bits just above the upstream ID.
    always_comb begin
        resp_port    = bus.dn_resp_i.trans_id[TransIdBits +: PortBits];
        resp_port_ok = (32'(resp_port) < NrPorts);
        resp_legal   = resp_port_ok && (cnt_q[resp_port] != '0);

        bus.up_resp_valid_o = '0;
        bus.dn_resp_ready_o = 1'b0;
        if (!rst_i) begin
            if (resp_port_ok) begin
                bus.up_resp_valid_o[resp_port] = bus.dn_resp_valid_i;
                bus.dn_resp_ready_o            = bus.up_resp_ready_i[resp_port];
            end else begin
                bus.dn_resp_ready_o = 1'b1;
            end
        end
        resp_hs = bus.dn_resp_valid_i && bus.dn_resp_ready_o && resp_legal;

        up_resp          = bus.dn_resp_i;
        up_resp.trans_id = '0;
        up_resp.trans_id[TransIdBits-1:0] = bus.dn_resp_i.trans_id[TransIdBits-1:0];
        bus.up_resp_o    = up_resp;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (req_hs) begin
            state_d  = LOCK_IDLE;
            rr_ptr_d = (32'(winner) == NrPorts - 1) ? '0 : winner + 1'b1;
        end else if (dn_valid) begin
            state_d    = LOCK_HELD;
            lock_idx_d = winner;
        end
    end

    // A grant and a response on the same port in one cycle cancel out.
    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            cnt_d[p] = cnt_q[p];
            if (req_hs && (winner == port_idx_t'(p))) begin
                if (!(resp_hs && (resp_port == port_idx_t'(p)))) begin
                    cnt_d[p] = cnt_q[p] + 1'b1;
                end
            end else if (resp_hs && (resp_port == port_idx_t'(p))) begin
                cnt_d[p] = cnt_q[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LOCK_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            for (int p = 0; p < int'(NrPorts); p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            for (int p = 0; p < int'(NrPorts); p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    always_comb begin
        bus.idle_o = (state_q == LOCK_IDLE);
        for (int p = 0; p < int'(NrPorts); p++) begin
            bus.outstanding_o[p] = cnt_q[p];
            if (cnt_q[p] != '0) begin
                bus.idle_o = 1'b0;
            end
        end
    end

    lock_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == LOCK_HELD) |-> bus.up_req_valid_i[lock_idx_q]);

    resp_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.dn_resp_valid_i |-> resp_legal);

endmodule

// File: tb/tb_acc_port_arbiter.sv
// tb/tb_acc_port_arbiter.sv - scoreboard bench for acc_port_arbiter with directed vectors
module tb_acc_port_arbiter;
    import acc_pkg::*;

    localparam int unsigned NrPorts = 2;
    localparam int unsigned MaxOut  = 4;
    localparam int unsigned TidBits = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [9:0] exp_req_q [$];
    logic [9:0] exp_resp_q [$];

    always #5 clk = ~clk;

    acc_port_arbiter_if #(.NrPorts(NrPorts), .MaxOutstanding(MaxOut)) bus ();

    acc_port_arbiter #(
        .NrPorts        (NrPorts),
        .MaxOutstanding (MaxOut),
        .TransIdBits    (TidBits)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] id);
        bus.up_req_valid_i[p]   = v;
        bus.up_req_i[p].insn     = 32'h0000_0013 + 32'(p);
        bus.up_req_i[p].rs1      = 32'h1000 + 32'(id);
        bus.up_req_i[p].rs2      = 32'h2000 + 32'(p);
        bus.up_req_i[p].frm      = 3'(p);
        bus.up_req_i[p].trans_id = {5'b0, id};
    endtask

    task automatic set_resp(input logic v, input logic [7:0] tid);
        bus.dn_resp_valid_i     = v;
        bus.dn_resp_i.result   = 32'hCAFE_0000 + 32'(tid);
        bus.dn_resp_i.error    = 1'b0;
        bus.dn_resp_i.trans_id = tid;
    endtask

    // Monitor: every observed handshake pops one expectation from its queue.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.dn_req_valid_o && bus.dn_req_ready_i) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant actual=%0h required=none",
                                 {bus.up_req_ready_o, bus.dn_req_o.trans_id});
                    end else begin
                        e = exp_req_q.pop_front();
                        chk("grant", 32'({bus.up_req_ready_o, bus.dn_req_o.trans_id}), 32'(e));
                    end
                end
                if ((bus.up_resp_valid_o & bus.up_resp_ready_i) != '0) begin
                    if (exp_resp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp actual=%0h required=none",
                                 {bus.up_resp_valid_o, bus.up_resp_o.trans_id});
                    end else begin
                        e = exp_resp_q.pop_front();
                        chk("resp", 32'({bus.up_resp_valid_o, bus.up_resp_o.trans_id}), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] tids [4];
        bus.up_req_valid_i  = '0;
        bus.up_resp_ready_i = '0;
        bus.dn_req_ready_i  = 1'b0;
        set_req(0, 1'b0, 3'd0);
        set_req(1, 1'b0, 3'd0);
        set_resp(1'b0, 8'h00);

        // Reset with live-looking inputs: every output must stay quiet.
        rst = 1'b1;
        set_req(0, 1'b1, 3'd1);
        set_req(1, 1'b1, 3'd2);
        bus.dn_req_ready_i  = 1'b1;
        bus.up_resp_ready_i = 2'b11;
        set_resp(1'b1, 8'h01);
        tick();
        tick();
        chk("rst_dn_req_valid", 32'(bus.dn_req_valid_o), 32'd0);
        chk("rst_up_req_ready", 32'(bus.up_req_ready_o), 32'd0);
        chk("rst_up_resp_valid", 32'(bus.up_resp_valid_o), 32'd0);
        chk("rst_dn_resp_ready", 32'(bus.dn_resp_ready_o), 32'd0);
        chk("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
        chk("rst_idle", 32'(bus.idle_o), 32'd1);
        set_req(0, 1'b0, 3'd0);
        set_req(1, 1'b0, 3'd0);
        set_resp(1'b0, 8'h00);
        bus.dn_req_ready_i = 1'b0;
        rst = 1'b0;
        tick();

        // Round-robin alternation with both ports valid.
        set_req(0, 1'b1, 3'd1);
        set_req(1, 1'b1, 3'd2);
        bus.dn_req_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_req_q.push_back({2'b01, 8'h01});
            exp_req_q.push_back({2'b10, 8'h0A});
        end
        repeat (4) tick();
        set_req(0, 1'b0, 3'd1);
        set_req(1, 1'b0, 3'd2);
        chk("rr_out0", 32'(bus.outstanding_o[0]), 32'd2);
        chk("rr_out1", 32'(bus.outstanding_o[1]), 32'd2);

        bus.up_resp_ready_i = 2'b11;
        tids = '{8'h01, 8'h0A, 8'h01, 8'h0A};
        for (int i = 0; i < 4; i++) begin
            set_resp(1'b1, tids[i]);
            exp_resp_q.push_back(tids[i][3] ? {2'b10, 8'h02} : {2'b01, 8'h01});
            tick();
        end
        set_resp(1'b0, 8'h00);
        chk("drain1_outstanding", 32'(bus.outstanding_o), 32'd0);
        chk("drain1_idle", 32'(bus.idle_o), 32'd1);

        // Lock: port 1 held under backpressure while port 0 arrives.
        bus.dn_req_ready_i = 1'b0;
        set_req(1, 1'b1, 3'd5);
        tick();
        set_req(0, 1'b1, 3'd3);
        @(negedge clk);
        chk("lock_dn_valid", 32'(bus.dn_req_valid_o), 32'd1);
        chk("lock_dn_tid", 32'(bus.dn_req_o.trans_id), 32'h0D);
        chk("lock_up_ready", 32'(bus.up_req_ready_o), 32'd0);
        chk("lock_idle", 32'(bus.idle_o), 32'd0);
        tick();
        tick();
        exp_req_q.push_back({2'b10, 8'h0D});
        bus.dn_req_ready_i = 1'b1;
        tick();
        set_req(1, 1'b0, 3'd5);
        exp_req_q.push_back({2'b01, 8'h03});
        tick();
        set_req(0, 1'b0, 3'd3);
        chk("lock_out0", 32'(bus.outstanding_o[0]), 32'd1);
        chk("lock_out1", 32'(bus.outstanding_o[1]), 32'd1);

        set_resp(1'b1, 8'h03);
        exp_resp_q.push_back({2'b01, 8'h03});
        tick();
        set_resp(1'b1, 8'h0D);
        exp_resp_q.push_back({2'b10, 8'h05});
        tick();
        set_resp(1'b0, 8'h00);

        // Port 0 fills to the cap, then port 1 wins every cycle.
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 3'(i));
            exp_req_q.push_back({2'b01, 8'(i)});
            tick();
        end
        chk("cap_out0", 32'(bus.outstanding_o[0]), 32'd4);
        set_req(0, 1'b1, 3'd4);
        set_req(1, 1'b1, 3'd6);
        for (int i = 0; i < 3; i++) begin
            exp_req_q.push_back({2'b10, 8'h0E});
            @(negedge clk);
            chk("cap_mask0", 32'(bus.up_req_ready_o[0]), 32'd0);
            tick();
        end
        set_req(0, 1'b0, 3'd4);
        set_req(1, 1'b0, 3'd6);
        chk("cap_out0_held", 32'(bus.outstanding_o[0]), 32'd4);
        chk("cap_out1", 32'(bus.outstanding_o[1]), 32'd3);

        // Response backpressured by port 0 for two cycles.
        bus.dn_req_ready_i  = 1'b0;
        bus.up_resp_ready_i = 2'b10;
        set_resp(1'b1, 8'h02);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_dn_resp_ready", 32'(bus.dn_resp_ready_o), 32'd0);
            chk("bp_up_resp_valid", 32'(bus.up_resp_valid_o), 32'd1);
            tick();
            chk("bp_out0", 32'(bus.outstanding_o[0]), 32'd4);
        end
        bus.up_resp_ready_i = 2'b11;
        exp_resp_q.push_back({2'b01, 8'h02});
        tick();
        set_resp(1'b0, 8'h00);
        chk("bp_out0_dec", 32'(bus.outstanding_o[0]), 32'd3);

        // Simultaneous grant and response on port 1.
        set_resp(1'b1, 8'h0E);
        exp_resp_q.push_back({2'b10, 8'h06});
        tick();
        set_resp(1'b0, 8'h00);
        chk("sim_pre_out1", 32'(bus.outstanding_o[1]), 32'd2);
        bus.dn_req_ready_i = 1'b1;
        set_req(1, 1'b1, 3'd7);
        set_resp(1'b1, 8'h0E);
        exp_req_q.push_back({2'b10, 8'h0F});
        exp_resp_q.push_back({2'b10, 8'h06});
        tick();
        set_req(1, 1'b0, 3'd7);
        set_resp(1'b0, 8'h00);
        chk("sim_out1", 32'(bus.outstanding_o[1]), 32'd2);

        // Reset while port 1 is locked and port 0 has 3 in flight.
        bus.dn_req_ready_i = 1'b0;
        set_req(1, 1'b1, 3'd4);
        tick();
        chk("prerst_idle", 32'(bus.idle_o), 32'd0);
        rst = 1'b1;
        set_resp(1'b1, 8'h02);
        bus.dn_req_ready_i = 1'b1;
        #1;
        chk("midrst_dn_valid", 32'(bus.dn_req_valid_o), 32'd0);
        chk("midrst_up_ready", 32'(bus.up_req_ready_o), 32'd0);
        chk("midrst_up_resp_valid", 32'(bus.up_resp_valid_o), 32'd0);
        chk("midrst_dn_resp_ready", 32'(bus.dn_resp_ready_o), 32'd0);
        chk("midrst_outstanding", 32'(bus.outstanding_o), 32'd0);
        chk("midrst_idle", 32'(bus.idle_o), 32'd1);
        tick();
        rst = 1'b0;
        set_resp(1'b0, 8'h00);
        set_req(1, 1'b0, 3'd4);
        bus.dn_req_ready_i = 1'b0;
        #1;
        chk("postrst_idle", 32'(bus.idle_o), 32'd1);
        chk("postrst_outstanding", 32'(bus.outstanding_o), 32'd0);
        set_req(0, 1'b1, 3'd1);
        set_req(1, 1'b1, 3'd2);
        bus.dn_req_ready_i = 1'b1;
        exp_req_q.push_back({2'b01, 8'h01});
        tick();
        set_req(0, 1'b0, 3'd1);
        set_req(1, 1'b0, 3'd2);
        bus.dn_req_ready_i = 1'b0;
        chk("postrst_out0", 32'(bus.outstanding_o[0]), 32'd1);

        tick();
        tick();
        chk("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
        chk("resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
